// File: rtl/riscv_instr_bus_arbiter.sv
// Round-robin arbiter sharing one OBI instruction-memory port between two requesters.
// Optional response tag passthrough is enabled with `define IBUS_ARB_RTAG_EN.
module riscv_instr_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RDATA_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_i,
  input  logic [31:0]            addr0_i,
  input  logic                   req1_i,
  input  logic [31:0]            addr1_i,
  output logic                   gnt0_o,
  output logic                   gnt1_o,
  output logic                   rvalid0_o,
  output logic                   rvalid1_o,
  output logic [RDATA_WIDTH-1:0] rdata_o,
  output logic                   err_o,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [RDATA_WIDTH-1:0] mem_rdata_i,
  input  logic                   mem_err_pmp_i,
  output logic                   busy_o,
  output logic                   proto_err_o
`ifdef IBUS_ARB_RTAG_EN
  ,
  input  logic [3:0]             mem_rtag_i,
  output logic [3:0]             rtag_o
`endif
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {ArbIdle, ArbHold} state_e;

  state_e                     state_q, state_d;
  logic                       last_q, last_d;
  logic                       sel_q, sel_d;
  logic                       sel, req_sel;
  logic                       push, pop, not_full, head;
  logic [MAX_OUTSTANDING-1:0] ids_q;
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            cnt_q;
  logic                       proto_err_q;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign not_full = (cnt_q < CntW'(MAX_OUTSTANDING));
  assign pop      = mem_rvalid_i && (cnt_q != '0);
  assign head     = ids_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    sel       = sel_q;
    req_sel   = 1'b0;
    mem_req_o = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        // Tie goes to the requester that did not win last.
        sel = (req0_i && req1_i) ? ~last_q : req1_i;
        if ((req0_i || req1_i) && not_full) begin
          mem_req_o = 1'b1;
          if (mem_gnt_i) begin
            push   = 1'b1;
            last_d = sel;
          end else begin
            sel_d   = sel;
            state_d = ArbHold;
          end
        end
      end
      ArbHold: begin
        req_sel = sel_q ? req1_i : req0_i;
        if (!req_sel) begin
          state_d = ArbIdle;
        end else if (not_full) begin
          mem_req_o = 1'b1;
          if (mem_gnt_i) begin
            push    = 1'b1;
            last_d  = sel_q;
            state_d = ArbIdle;
          end
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  assign mem_addr_o  = mem_req_o ? (sel ? addr1_i : addr0_i) : '0;
  assign gnt0_o      = push && !sel;
  assign gnt1_o      = push && sel;
  assign rvalid0_o   = pop && !head;
  assign rvalid1_o   = pop && head;
  assign rdata_o     = pop ? mem_rdata_i : '0;
  assign err_o       = pop && mem_err_pmp_i;
  assign busy_o      = (cnt_q != '0) || mem_req_o;
  assign proto_err_o = proto_err_q;
`ifdef IBUS_ARB_RTAG_EN
  assign rtag_o      = pop ? mem_rtag_i : 4'h0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ArbIdle;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      ids_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      if (push) begin
        ids_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (mem_rvalid_i && (cnt_q == '0)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_instr_bus_arbiter.sv
// Directed bench for riscv_instr_bus_arbiter: inline checks on the request side, scoreboard
// queue checked by a monitor on every routed response.
module tb_riscv_instr_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_i, req1_i;
  logic [31:0] addr0_i, addr1_i;
  logic        gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [31:0] rdata_o;
  logic        err_o, mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_pmp_i;
  logic        busy_o, proto_err_o;
`ifdef IBUS_ARB_RTAG_EN
  logic [3:0]  mem_rtag_i;
  logic [3:0]  rtag_o;
`endif

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t e;
  int   total = 0;
  int   bad   = 0;

  riscv_instr_bus_arbiter #(
    .MAX_OUTSTANDING(2),
    .RDATA_WIDTH    (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_i       (req0_i),
    .addr0_i      (addr0_i),
    .req1_i       (req1_i),
    .addr1_i      (addr1_i),
    .gnt0_o       (gnt0_o),
    .gnt1_o       (gnt1_o),
    .rvalid0_o    (rvalid0_o),
    .rvalid1_o    (rvalid1_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_pmp_i(mem_err_pmp_i),
    .busy_o       (busy_o),
    .proto_err_o  (proto_err_o)
`ifdef IBUS_ARB_RTAG_EN
    ,
    .mem_rtag_i   (mem_rtag_i),
    .rtag_o       (rtag_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req0_i        = 1'b0;
    req1_i        = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    mem_err_pmp_i = 1'b0;
`ifdef IBUS_ARB_RTAG_EN
    mem_rtag_i    = 4'h0;
`endif
  endtask

  // Drive a memory response this cycle and record where it must land.
  task automatic rsp(input logic id, input logic [31:0] data, input logic err,
                     input logic [3:0] tag);
    rsp_t r;
    mem_rvalid_i  = 1'b1;
    mem_rdata_i   = data;
    mem_err_pmp_i = err;
`ifdef IBUS_ARB_RTAG_EN
    mem_rtag_i    = tag;
`endif
    r.id   = id;
    r.data = data;
    r.err  = err;
    r.tag  = tag;
    exp_q.push_back(r);
  endtask

  task automatic chk_req(input string name, input logic mreq, input logic [31:0] maddr,
                         input logic g0, input logic g1);
    chk({name, "_mem_req"}, mem_req_o, mreq);
    chk({name, "_mem_addr"}, mem_addr_o, maddr);
    chk({name, "_gnt0"}, gnt0_o, g0);
    chk({name, "_gnt1"}, gnt1_o, g1);
  endtask

  always @(negedge clk) begin
    if (rst_n && (rvalid0_o || rvalid1_o)) begin
      chk("rvalid_onehot", {31'd0, rvalid0_o & rvalid1_o}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rvalid0=%0b rvalid1=%0b want none",
                 rvalid0_o, rvalid1_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", {31'd0, rvalid1_o}, {31'd0, e.id});
        chk("rsp_data", rdata_o, e.data);
        chk("rsp_err", {31'd0, err_o}, {31'd0, e.err});
`ifdef IBUS_ARB_RTAG_EN
        chk("rsp_tag", {28'd0, rtag_o}, {28'd0, e.tag});
`endif
      end
    end
  end

  initial begin
    idle_in();
    addr0_i = '0;
    addr1_i = '0;
    rst_n   = 1'b0;
    repeat (2) next();
    chk_req("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset_busy", busy_o, 0);
    chk("reset_proto", proto_err_o, 0);
    chk("reset_rdata", rdata_o, 0);
    chk("reset_rvalid", {rvalid0_o, rvalid1_o}, 0);
    chk("reset_err", err_o, 0);
`ifdef IBUS_ARB_RTAG_EN
    chk("reset_rtag", rtag_o, 0);
`endif
    rst_n = 1'b1;
    next();

    // Single requester 0, immediate grant, response next cycle.
    req0_i = 1'b1; addr0_i = 32'h0000_0080; mem_gnt_i = 1'b1;
    #1 chk_req("single", 1'b1, 32'h80, 1'b1, 1'b0);
    next();
    idle_in(); rsp(1'b0, 32'h0000_0013, 1'b0, 4'h0);
    #1 chk("single_busy", busy_o, 1);
    next();

    // Both requesting, grant every cycle: last winner was 0, so 1 goes first.
    idle_in();
    req0_i = 1'b1; addr0_i = 32'h100; req1_i = 1'b1; addr1_i = 32'h200; mem_gnt_i = 1'b1;
    #1 chk_req("rr_a", 1'b1, 32'h200, 1'b0, 1'b1);
    next();
    rsp(1'b1, 32'h0000_00A1, 1'b0, 4'h0);
    #1 chk_req("rr_b", 1'b1, 32'h100, 1'b1, 1'b0);
    next();
    rsp(1'b0, 32'h0000_00A2, 1'b0, 4'h0);
    #1 chk_req("rr_c", 1'b1, 32'h200, 1'b0, 1'b1);
    next();
    idle_in(); rsp(1'b1, 32'h0000_00A3, 1'b1, 4'hA);
    next();

    // Held request keeps address stable while the other requester rises.
    idle_in();
    req1_i = 1'b1; addr1_i = 32'h1A11_0800;
    #1 chk_req("hold_0", 1'b1, 32'h1A11_0800, 1'b0, 1'b0);
    next();
    req0_i = 1'b1; addr0_i = 32'h300;
    #1 chk_req("hold_1", 1'b1, 32'h1A11_0800, 1'b0, 1'b0);
    next();
    #1 chk_req("hold_2", 1'b1, 32'h1A11_0800, 1'b0, 1'b0);
    next();
    mem_gnt_i = 1'b1;
    #1 chk_req("hold_gnt", 1'b1, 32'h1A11_0800, 1'b0, 1'b1);
    next();
    req1_i = 1'b0; rsp(1'b1, 32'h0000_00B1, 1'b0, 4'h0);
    #1 chk_req("after_hold", 1'b1, 32'h300, 1'b1, 1'b0);
    next();

    // Fill to MAX_OUTSTANDING=2, then full blocks even with a same-cycle rvalid.
    mem_rvalid_i = 1'b0; addr0_i = 32'h304;
    #1 chk_req("fill", 1'b1, 32'h304, 1'b1, 1'b0);
    next();
    addr0_i = 32'h308; rsp(1'b0, 32'h0000_00B2, 1'b0, 4'h0);
    #1 chk_req("full", 1'b0, 32'h0, 1'b0, 1'b0);
    next();
    mem_rvalid_i = 1'b0;
    #1 chk_req("freed", 1'b1, 32'h308, 1'b1, 1'b0);
    next();
    idle_in(); rsp(1'b0, 32'h0000_00B3, 1'b0, 4'h0);
    next();
    idle_in(); rsp(1'b0, 32'h0000_00B4, 1'b0, 4'h0);
    next();

    // Requester drops its request while held: no push, no grant.
    idle_in(); req0_i = 1'b1; addr0_i = 32'h400;
    #1 chk_req("drop_0", 1'b1, 32'h400, 1'b0, 1'b0);
    next();
    req0_i = 1'b0; req1_i = 1'b1; addr1_i = 32'h500;
    #1 chk_req("drop_1", 1'b0, 32'h0, 1'b0, 1'b0);
    next();
    mem_gnt_i = 1'b1;
    #1 chk_req("drop_2", 1'b1, 32'h500, 1'b0, 1'b1);
    next();
    idle_in(); rsp(1'b1, 32'h0000_00C1, 1'b0, 4'h0);
    next();

    // Response with nothing outstanding.
    idle_in(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1 chk("proto_rvalid", {rvalid0_o, rvalid1_o}, 0);
    chk("proto_busy", busy_o, 0);
    chk("proto_pre", proto_err_o, 0);
    next();
    idle_in();
    #1 chk("proto_set", proto_err_o, 1);
    repeat (2) next();
    chk("proto_sticky", proto_err_o, 1);

    // Leave one transaction outstanding, then reset discards it.
    req0_i = 1'b1; mem_gnt_i = 1'b1; addr0_i = 32'h600;
    next();
    idle_in(); rst_n = 1'b0;
    next();
    chk("rst2_proto", proto_err_o, 0);
    chk("rst2_busy", busy_o, 0);
    rst_n = 1'b1;
    next();

    // First tie after reset goes to requester 0.
    req0_i = 1'b1; addr0_i = 32'h700; req1_i = 1'b1; addr1_i = 32'h800; mem_gnt_i = 1'b1;
    #1 chk_req("tie_0", 1'b1, 32'h700, 1'b1, 1'b0);
    next();
    #1 chk_req("tie_1", 1'b1, 32'h800, 1'b0, 1'b1);
    next();
    idle_in(); rsp(1'b0, 32'h0000_00D0, 1'b0, 4'h0);
    next();
    idle_in(); rsp(1'b1, 32'h0000_00D1, 1'b1, 4'h5);
    next();
    idle_in();
    repeat (2) next();
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("end_proto", proto_err_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
